// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC generation, instruction-memory request issue,
// in-order instruction FIFO and branch redirect/flush of younger fetches.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        PC_src,
    input  logic [31:0] branch_target
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;

    logic          pop;
    logic          flush;
    logic          req_fire;
    logic          rsp_ok;
    logic          push;
    logic [CW:0]   inflight;
    logic [31:0]   target_aligned;

    // Outstanding requests plus buffered words never exceed DEPTH, so every
    // response has a guaranteed FIFO slot and no word can be lost.
    always_comb begin
        inflight       = {1'b0, outst} + {1'b0, occ};
        target_aligned = branch_target & ~32'h0000_0003;
        inst_valid     = (occ != '0);
        pop            = inst_valid && inst_ready;
        flush          = pop && PC_src;
        imem_req_valid = !rst && !flush && (inflight < DEPTH_W);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_ok         = imem_rsp_valid && (outst != '0);
        push           = rsp_ok && (drop == '0) && !flush;
        instruction    = inst_valid ? fifo_word[rd_ptr] : NOP;
        inst_pc        = inst_valid ? fifo_pc[rd_ptr] : 32'h0;
    end

    // rsp_pc tracks the PC of the next kept response; dropped responses
    // belong to the old stream and never advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            outst    <= '0;
            drop     <= '0;
        end else begin
            outst <= outst + CW'(req_fire) - CW'(rsp_ok);
            if (flush) begin
                fetch_pc <= target_aligned;
                rsp_pc   <= target_aligned;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                occ      <= '0;
                drop     <= outst - CW'(rsp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_ok && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                occ <= occ + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order scoreboard of accepted fetches against the
// presented instructions, with per-scenario timing checks.
`timescale 1ns/1ps
module tb_ifetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        PC_src = 1'b0;
    logic [31:0] branch_target = 32'h0;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = 32'h0;
    logic        w_inst_valid;
    logic [31:0] w_instruction;
    logic [31:0] w_inst_pc;
    logic        w_one = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_target = 32'h0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
        .PC_src(PC_src), .branch_target(branch_target)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_one), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .inst_valid(w_inst_valid), .inst_ready(w_one), .instruction(w_instruction), .inst_pc(w_inst_pc),
        .PC_src(w_zero), .branch_target(w_target)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] v; logic [31:0] d; int c; } log_t;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    log_t        req_log[$];
    log_t        pop_log[$];
    log_t        w_req_log[$];
    log_t        w_pop_log[$];
    logic        w_pend = 1'b0;
    logic [31:0] w_pend_addr = 32'h0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013 ^ {a[15:0], 16'h0};
    endfunction

    // Memory models: in-order responses a fixed latency after acceptance.
    always @(posedge clk) begin
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_of(pend_q[0].addr);
            pend_q.delete(0);
        end
        w_rsp_valid = w_pend;
        w_rsp_data  = data_of(w_pend_addr);
        w_pend      = 1'b0;
    end

    // Scoreboard: pops are compared against accepted fetches in order.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        if (inst_valid && inst_ready) begin
            pop_log.push_back(log_t'{v: inst_pc, d: instruction, c: cyc});
            n_checks++;
            if (exp_q.size() == 0)
                $display("[TB] FAIL sb_pop: got pc %h, want no instruction", inst_pc);
            else if (inst_pc !== exp_q[0] || instruction !== data_of(exp_q[0]))
                $display("[TB] FAIL sb_pop: got pc %h data %h, want pc %h data %h", inst_pc, instruction, exp_q[0], data_of(exp_q[0]));
            else n_pass++;
            if (exp_q.size() > 0) exp_q.delete(0);
            if (PC_src) begin
                exp_q.delete();
                n_checks++;
                if (imem_req_valid !== 1'b0) $display("[TB] FAIL flush_req: got %b want 0", imem_req_valid);
                else n_pass++;
            end
        end else if (!inst_valid) begin
            n_checks++;
            if (instruction !== NOP || inst_pc !== 32'h0)
                $display("[TB] FAIL idle_out: got %h/%h want %h/0", instruction, inst_pc, NOP);
            else n_pass++;
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_q.push_back(pend_t'{addr: imem_req_addr, due: cyc + mem_lat});
            exp_q.push_back(imem_req_addr);
            req_log.push_back(log_t'{v: imem_req_addr, d: 32'h0, c: cyc});
        end
        if (w_req_valid) begin
            w_pend      = 1'b1;
            w_pend_addr = w_req_addr;
            w_req_log.push_back(log_t'{v: w_req_addr, d: 32'h0, c: cyc});
        end
        if (w_inst_valid) w_pop_log.push_back(log_t'{v: w_inst_pc, d: w_instruction, c: cyc});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit clear_mem);
        tick();
        rst = 1'b1;
        if (clear_mem) pend_q.delete();
        tick();
        tick();
        rst = 1'b0;
        req_log.delete();
        pop_log.delete();
        w_req_log.delete();
        w_pop_log.delete();
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b1; PC_src = 1'b0; mem_lat = 1;
        tick();
        rst = 1'b1;
        pend_q.delete();
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL rst_inst_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (instruction !== NOP) $display("[TB] FAIL rst_instruction: got %h want %h", instruction, NOP); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL rst_inst_pc: got %h want 0", inst_pc); else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b1) $display("[TB] FAIL first_req_valid: got %b want 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL first_req_addr: got %h want 0", imem_req_addr); else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_zero_wait();
        mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset(1'b1);
        repeat (8) tick();
        @(negedge clk);
        n_checks++; if (req_log.size() < 3 || pop_log.size() < 5)
            $display("[TB] FAIL zw_counts: got %0d req %0d pop want >=3 >=5", req_log.size(), pop_log.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < req_log.size(); i++) begin
            n_checks++;
            if (req_log[i].v !== 32'(4 * i) || req_log[i].c != req_log[0].c + i)
                $display("[TB] FAIL zw_req%0d: got %h@%0d want %h@%0d", i, req_log[i].v, req_log[i].c, 32'(4 * i), req_log[0].c + i);
            else n_pass++;
        end
        for (int i = 0; i < 5 && i < pop_log.size() && req_log.size() > 0; i++) begin
            n_checks++;
            if (pop_log[i].v !== 32'(4 * i) || pop_log[i].c != req_log[0].c + 2 + i)
                $display("[TB] FAIL zw_pop%0d: got %h@%0d want %h@%0d", i, pop_log[i].v, pop_log[i].c, 32'(4 * i), req_log[0].c + 2 + i);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
        do_reset(1'b1);
        repeat (10) tick();
        @(negedge clk);
        n_checks++; if (req_log.size() != 4) $display("[TB] FAIL bp_req_count: got %0d want 4", req_log.size()); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
            $display("[TB] FAIL bp_head: got valid %b pc %h want 1 0", inst_valid, inst_pc);
        else n_pass++;
        tick();
        inst_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        n_checks++; if (pop_log.size() < 5) $display("[TB] FAIL bp_pop_count: got %0d want >= 5", pop_log.size()); else n_pass++;
        for (int i = 0; i < 5 && i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i].v !== 32'(4 * i) || pop_log[i].c != pop_log[0].c + i)
                $display("[TB] FAIL bp_pop%0d: got %h@%0d want %h@%0d", i, pop_log[i].v, pop_log[i].c, 32'(4 * i), pop_log[0].c + i);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        int  k = 0;
        int  ridx = 0;
        bit  done = 1'b0;
        mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1; PC_src = 1'b0;
        do_reset(1'b1);
        for (int c = 0; c < 24; c++) begin
            tick();
            if (!done && inst_valid && inst_pc == 32'h4) begin
                PC_src = 1'b1; branch_target = 32'h0000_0103; done = 1'b1;
                k = pop_log.size(); ridx = req_log.size();
            end else PC_src = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (!done || pop_log.size() < k + 2 || req_log.size() < ridx + 1)
            $display("[TB] FAIL rd_progress: got flush %b pops %0d want flush 1 pops >= %0d", done, pop_log.size(), k + 2);
        else begin
            n_pass++;
            n_checks++; if (req_log[ridx].v !== 32'h100 || req_log[ridx].c != pop_log[k].c + 1)
                $display("[TB] FAIL rd_req: got %h@%0d want 00000100@%0d", req_log[ridx].v, req_log[ridx].c, pop_log[k].c + 1);
            else n_pass++;
            n_checks++; if (pop_log[k + 1].v !== 32'h100 || pop_log[k + 1].c != pop_log[k].c + 5)
                $display("[TB] FAIL rd_pop: got %h@%0d want 00000100@%0d", pop_log[k + 1].v, pop_log[k + 1].c, pop_log[k].c + 5);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int k2 = 0;
        int ridx2 = 0;
        int stage = 0;
        mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1; PC_src = 1'b0;
        do_reset(1'b1);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (stage == 0 && inst_valid && inst_pc == 32'h4) begin
                PC_src = 1'b1; branch_target = 32'h0000_0103; stage = 1;
            end else if (stage == 1 && inst_valid) begin
                PC_src = 1'b1; branch_target = 32'h0000_0200; stage = 2;
                k2 = pop_log.size(); ridx2 = req_log.size();
            end else PC_src = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (stage != 2 || pop_log.size() < k2 + 2 || req_log.size() < ridx2 + 1)
            $display("[TB] FAIL b2b_progress: got stage %0d pops %0d want stage 2 pops >= %0d", stage, pop_log.size(), k2 + 2);
        else begin
            n_pass++;
            n_checks++; if (pop_log[k2].v !== 32'h100) $display("[TB] FAIL b2b_first: got %h want 00000100", pop_log[k2].v); else n_pass++;
            n_checks++; if (req_log[ridx2].v !== 32'h200) $display("[TB] FAIL b2b_req: got %h want 00000200", req_log[ridx2].v); else n_pass++;
            n_checks++; if (pop_log[k2 + 1].v !== 32'h200) $display("[TB] FAIL b2b_next: got %h want 00000200", pop_log[k2 + 1].v); else n_pass++;
        end
    endtask

    task automatic test_reset_stray();
        mem_lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1; PC_src = 1'b0;
        do_reset(1'b1);
        tick();
        tick();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        req_log.delete();
        pop_log.delete();
        repeat (2) tick();
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0 || pop_log.size() != 0)
            $display("[TB] FAIL stray_ignored: got valid %b pops %0d want 0 0", inst_valid, pop_log.size());
        else n_pass++;
        tick();
        imem_req_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        n_checks++; if (pop_log.size() < 1 || req_log.size() < 1)
            $display("[TB] FAIL stray_first: got %0d pops want >= 1", pop_log.size());
        else if (pop_log[0].v !== 32'h0 || pop_log[0].d !== data_of(32'h0) || pop_log[0].c != req_log[0].c + 4)
            $display("[TB] FAIL stray_first: got %h/%h@%0d want 0/%h@%0d", pop_log[0].v, pop_log[0].d, pop_log[0].c, data_of(32'h0), req_log[0].c + 4);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        mem_lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1; PC_src = 1'b0;
        do_reset(1'b1);
        repeat (6) tick();
        @(negedge clk);
        n_checks++; if (w_req_log.size() < 3 || w_pop_log.size() < 3)
            $display("[TB] FAIL wrap_counts: got %0d req %0d pop want >= 3", w_req_log.size(), w_pop_log.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < w_req_log.size(); i++) begin
            n_checks++;
            if (w_req_log[i].v !== want[i]) $display("[TB] FAIL wrap_req%0d: got %h want %h", i, w_req_log[i].v, want[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3 && i < w_pop_log.size(); i++) begin
            n_checks++;
            if (w_pop_log[i].v !== want[i] || w_pop_log[i].d !== data_of(want[i]))
                $display("[TB] FAIL wrap_pop%0d: got %h/%h want %h/%h", i, w_pop_log[i].v, w_pop_log[i].d, want[i], data_of(want[i]));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_stray();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
